// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the GPR writeback arbiter.
package wb_pkg;

  localparam int DWidth    = 32;
  localparam int NumofReg  = 32;
  localparam int FifoDepth = 4;
  localparam int MaxWait   = 8;

  localparam int AWidth    = $clog2(NumofReg);
  localparam int CntWidth  = $clog2(FifoDepth + 1);
  localparam int PtrWidth  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int WaitWidth = $clog2(MaxWait + 1);

  // One register-file write: destination GPR and value.
  typedef struct packed {
    logic [AWidth-1:0] addr;
    logic [DWidth-1:0] data;
  } wb_req_t;

  // One-hot mask selecting GPR idx.
  function automatic logic [NumofReg-1:0] reg_onehot(input logic [AWidth-1:0] idx);
    return {{(NumofReg-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: pipeline source A, long-latency source B, issue tracking,
// register-file write port and hazard-unit outputs.
interface wb_if;
  import wb_pkg::*;

  logic                a_valid_i;
  logic [AWidth-1:0]   a_addr_i;
  logic [DWidth-1:0]   a_data_i;
  logic                b_valid_i;
  logic                b_ready_o;
  logic [AWidth-1:0]   b_addr_i;
  logic [DWidth-1:0]   b_data_i;
  logic                issue_valid_i;
  logic [AWidth-1:0]   issue_rd_i;
  logic                write_en_o;
  logic [AWidth-1:0]   write_addr_o;
  logic [DWidth-1:0]   write_data_o;
  logic [NumofReg-1:0] pending_o;
  logic                stall_o;

  // Producer side (pipeline, long-latency unit, issue logic).
  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    output issue_valid_i, issue_rd_i,
    input  b_ready_o, write_en_o, write_addr_o, write_data_o, pending_o, stall_o
  );

  // Arbiter side.
  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    input  issue_valid_i, issue_rd_i,
    output b_ready_o, write_en_o, write_addr_o, write_data_o, pending_o, stall_o
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Source-B result buffer: circular FIFO of wb_req_t built from enabled D flip-flops.

// Plain enabled register used as one FIFO slot.
module d_ff #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Capture the slot contents on a write.
  // NOTE: slot storage has no reset; validity lives in the FIFO pointers/count, so stale data is never read.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (en_i) q_o <= d_i;
  end

endmodule

module wb_fifo
  import wb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  wb_req_t             data_i,
  output wb_req_t             head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(FifoDepth - 1);

  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  wb_req_t             w_slot [FifoDepth];

  for (genvar i = 0; i < FifoDepth; i++) begin : g_slot
    d_ff #(.Width($bits(wb_req_t))) u_dff (
      .clk_i (clk_i),
      .en_i  (push_i && (r_wr_ptr == PtrWidth'(i))),
      .d_i   (data_i),
      .q_o   (w_slot[i])
    );
  end

  assign head_o  = w_slot[r_rd_ptr];
  assign count_o = r_count;

  // Advance pointers modulo FifoDepth and track occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
      if (pop_i)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback merge stage: A (pipeline) beats buffered B (long-latency) onto the
// single GPR write port; tracks pending long-latency destinations and raises
// stall_o when the B buffer head is starved.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  wb_if.slave  bus
);

  localparam logic [CntWidth-1:0]  FullCount = CntWidth'(FifoDepth);
  localparam logic [WaitWidth-1:0] WaitLimit = WaitWidth'(MaxWait - 1);
  localparam logic [NumofReg-1:0]  NoX0Mask  = {{(NumofReg-1){1'b1}}, 1'b0};

  logic [CntWidth-1:0]  w_count;
  wb_req_t              w_head;
  wb_req_t              w_a_req;
  wb_req_t              w_b_req;
  wb_req_t              w_sel;
  logic                 w_b_ready, w_b_accept, w_a_win, w_fifo_ne;
  logic                 w_pop, w_bypass, w_push, w_sel_en, w_sel_is_b;
  logic [NumofReg-1:0]  w_set_vec, w_clr_vec;

  logic                 r_write_en;
  logic [AWidth-1:0]    r_write_addr;
  logic [DWidth-1:0]    r_write_data;
  logic [NumofReg-1:0]  r_pending;
  logic [WaitWidth-1:0] r_wait_cnt;
  logic                 r_stall;

  // Ready depends only on the registered occupancy, never on b_valid_i.
  assign w_b_ready  = (w_count < FullCount);
  assign w_b_accept = bus.b_valid_i & w_b_ready;
  assign w_a_req    = '{addr: bus.a_addr_i, data: bus.a_data_i};
  assign w_b_req    = '{addr: bus.b_addr_i, data: bus.b_data_i};
  assign w_a_win    = bus.a_valid_i & (bus.a_addr_i != '0);
  assign w_fifo_ne  = (w_count != '0);
  assign w_pop      = ~w_a_win & w_fifo_ne;
  assign w_bypass   = ~w_a_win & ~w_fifo_ne & w_b_accept & (bus.b_addr_i != '0);
  // Accepted x0 results are dropped; bypassed results never occupy a slot.
  assign w_push     = w_b_accept & (bus.b_addr_i != '0) & ~w_bypass;
  assign w_sel_en   = w_a_win | w_pop | w_bypass;
  assign w_sel_is_b = w_pop | w_bypass;

  wb_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_b_req),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // Priority select: A, then FIFO head, then direct B bypass.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_sel unassigned (no latch).
    w_sel = w_b_req;
    if (w_a_win)    w_sel = w_a_req;
    else if (w_pop) w_sel = w_head;
  end

  assign w_clr_vec = w_sel_is_b ? reg_onehot(w_sel.addr) : '0;
  assign w_set_vec = (bus.issue_valid_i && (bus.issue_rd_i != '0)) ? reg_onehot(bus.issue_rd_i) : '0;

  // Register the selected write; address/data hold when nothing is written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_sel_en;
      if (w_sel_en) begin
        r_write_addr <= w_sel.addr;
        r_write_data <= w_sel.data;
      end
    end
  end

  // Pending scoreboard: clear on B write, set on issue (set wins), x0 never pending.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_pending <= '0;
    else         r_pending <= ((r_pending & ~w_clr_vec) | w_set_vec) & NoX0Mask;
  end

  // Starvation tracking of the FIFO head; counter saturates at the stall threshold.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else if (w_pop) begin
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else if (w_fifo_ne) begin
      if (r_wait_cnt < WaitLimit) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt >= WaitLimit) r_stall <= 1'b1;
    end
  end

  assign bus.b_ready_o    = w_b_ready;
  assign bus.write_en_o   = r_write_en;
  assign bus.write_addr_o = r_write_addr;
  assign bus.write_data_o = r_write_data;
  assign bus.pending_o    = r_pending;
  assign bus.stall_o      = r_stall;

  // A must not overwrite a register still owed by the long-latency unit.
  a_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.a_valid_i |-> !r_pending[bus.a_addr_i]);

  // Issue to an already-pending register must be held off upstream.
  issue_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.issue_valid_i && (bus.issue_rd_i != '0)) |-> !r_pending[bus.issue_rd_i]);

  // Upstream must hold A idle while stall is requested.
  a_idle_in_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_stall |-> !bus.a_valid_i);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  wb_if bus ();

  wb_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  wb_req_t               m_q[$];
  bit                    m_valid = 1'b0;
  logic                  m_we;
  logic [AWidth-1:0]     m_addr;
  logic [DWidth-1:0]     m_data;
  logic [NumofReg-1:0]   m_pend;
  int                    m_starve;
  logic                  m_stall;
  bit                    had_items, took_b, wrote, from_b;
  wb_req_t               w, nb;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;
      m_starve = 0; m_stall = 1'b0; m_valid = 1'b1;
    end else begin
      had_items = (m_q.size() != 0);
      took_b    = bus.b_valid_i && (m_q.size() < FifoDepth);
      wrote = 1'b0; from_b = 1'b0; w = '0;
      nb.addr = bus.b_addr_i; nb.data = bus.b_data_i;
      if (bus.a_valid_i && bus.a_addr_i != 0) begin
        wrote = 1'b1; w.addr = bus.a_addr_i; w.data = bus.a_data_i;
      end else if (had_items) begin
        wrote = 1'b1; from_b = 1'b1; w = m_q.pop_front();
      end else if (took_b && bus.b_addr_i != 0) begin
        wrote = 1'b1; from_b = 1'b1; w = nb; took_b = 1'b0;
      end
      if (took_b && bus.b_addr_i != 0) m_q.push_back(nb);
      if (from_b) m_pend[w.addr] = 1'b0;
      if (bus.issue_valid_i && bus.issue_rd_i != 0) m_pend[bus.issue_rd_i] = 1'b1;
      if (from_b && had_items) begin
        m_starve = 0; m_stall = 1'b0;
      end else if (had_items) begin
        m_starve++;
        if (m_starve >= MaxWait) m_stall = 1'b1;
      end
      m_we = wrote;
      if (wrote) begin m_addr = w.addr; m_data = w.data; end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_write_en",   64'(bus.write_en_o),   64'(m_we));
      check("cmp_write_addr", 64'(bus.write_addr_o), 64'(m_addr));
      check("cmp_write_data", 64'(bus.write_data_o), 64'(m_data));
      check("cmp_pending",    64'(bus.pending_o),    64'(m_pend));
      check("cmp_stall",      64'(bus.stall_o),      64'(m_stall));
      check("cmp_b_ready",    64'(bus.b_ready_o),    64'(m_q.size() < FifoDepth));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid_i = 1'b0; bus.a_addr_i = '0; bus.a_data_i = '0;
    bus.b_valid_i = 1'b0; bus.b_addr_i = '0; bus.b_data_i = '0;
    bus.issue_valid_i = 1'b0; bus.issue_rd_i = '0;
  endtask

  task automatic drive_a(input int addr, input int data);
    bus.a_valid_i = 1'b1; bus.a_addr_i = AWidth'(addr); bus.a_data_i = DWidth'(data);
  endtask

  task automatic drive_b(input int addr, input int data);
    bus.b_valid_i = 1'b1; bus.b_addr_i = AWidth'(addr); bus.b_data_i = DWidth'(data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_we",      64'(bus.write_en_o),   64'd0);
    check("rst_addr",    64'(bus.write_addr_o), 64'd0);
    check("rst_data",    64'(bus.write_data_o), 64'd0);
    check("rst_pending", 64'(bus.pending_o),    64'd0);
    check("rst_stall",   64'(bus.stall_o),      64'd0);
    check("rst_b_ready", 64'(bus.b_ready_o),    64'd1);
    rst_n = 1'b1;
    step();

    // 1) A alone
    drive_a(5, 32'h1234);
    step();
    check("t1_we",   64'(bus.write_en_o),   64'd1);
    check("t1_addr", 64'(bus.write_addr_o), 64'd5);
    check("t1_data", 64'(bus.write_data_o), 64'h1234);
    idle();
    step();
    check("t1_idle_we",   64'(bus.write_en_o),   64'd0);
    check("t1_hold_addr", 64'(bus.write_addr_o), 64'd5);

    // 2) A and B together with empty FIFO
    drive_a(3, 32'h33);
    drive_b(7, 32'h77);
    step();
    check("t2_a_addr",  64'(bus.write_addr_o), 64'd3);
    check("t2_ready_1", 64'(bus.b_ready_o),    64'd1);
    idle();
    step();
    check("t2_b_we",    64'(bus.write_en_o),   64'd1);
    check("t2_b_addr",  64'(bus.write_addr_o), 64'd7);
    check("t2_b_data",  64'(bus.write_data_o), 64'h77);
    check("t2_ready_2", 64'(bus.b_ready_o),    64'd1);
    step();

    // 3) Scoreboard across a buffered B return
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = AWidth'(9);
    step();
    bus.issue_valid_i = 1'b0; bus.issue_rd_i = '0;
    check("t3_pend_set", 64'(bus.pending_o), 64'h200);
    for (int k = 0; k < 4; k++) begin
      drive_a(10 + k, k);
      if (k == 0) drive_b(9, 32'hBEEF);
      else begin bus.b_valid_i = 1'b0; bus.b_addr_i = '0; end
      step();
      check("t3_a_addr",   64'(bus.write_addr_o), 64'(10 + k));
      check("t3_pend_hold", 64'(bus.pending_o),   64'h200);
    end
    idle();
    step();
    check("t3_pop_addr", 64'(bus.write_addr_o), 64'd9);
    check("t3_pop_data", 64'(bus.write_data_o), 64'hBEEF);
    check("t3_pend_clr", 64'(bus.pending_o),    64'd0);

    // 4) Fill the FIFO behind A, then drain in order
    for (int k = 0; k < 4; k++) begin
      drive_a(20 + k, 32'hA0 + k);
      drive_b(1 + k, 32'h101 + k);
      step();
    end
    check("t4_full_ready", 64'(bus.b_ready_o), 64'd0);
    bus.a_valid_i = 1'b0;
    drive_b(5, 32'h105);
    step();
    check("t4_pop1_addr",  64'(bus.write_addr_o), 64'd1);
    check("t4_pop1_data",  64'(bus.write_data_o), 64'h101);
    check("t4_ready_back", 64'(bus.b_ready_o),    64'd1);
    idle();
    for (int k = 1; k < 4; k++) begin
      step();
      check("t4_pop_addr", 64'(bus.write_addr_o), 64'(1 + k));
      check("t4_pop_data", 64'(bus.write_data_o), 64'(32'h101 + k));
    end
    step();
    check("t4_empty_we", 64'(bus.write_en_o), 64'd0);

    // 5) Starvation: head waits behind continuous A
    drive_a(21, 32'h5A);
    drive_b(6, 32'h66);
    step();
    bus.b_valid_i = 1'b0; bus.b_addr_i = '0;
    cnt = 0;
    while (!bus.stall_o && cnt < 20) begin
      step();
      cnt++;
    end
    check("t5_stall_cycles", 64'(cnt), 64'd8);
    bus.a_valid_i = 1'b0;
    step();
    check("t5_pop_addr",  64'(bus.write_addr_o), 64'd6);
    check("t5_stall_clr", 64'(bus.stall_o),      64'd0);

    // 6) x0 targets, bypass, reset with entries queued
    drive_a(0, 32'hBEAD);
    drive_b(0, 32'hDEAD);
    step();
    check("t6_x0_we",      64'(bus.write_en_o),   64'd0);
    check("t6_x0_pending", 64'(bus.pending_o),    64'd0);
    check("t6_x0_hold",    64'(bus.write_addr_o), 64'd6);
    drive_b(8, 32'h88);
    step();
    check("t6_bypass_addr", 64'(bus.write_addr_o), 64'd8);
    check("t6_bypass_data", 64'(bus.write_data_o), 64'h88);
    for (int k = 0; k < 3; k++) begin
      drive_a(22, k);
      drive_b(11 + k, 32'h110 + k);
      step();
    end
    idle();
    rst_n = 1'b0;
    step();
    check("t6_rst_we",      64'(bus.write_en_o),   64'd0);
    check("t6_rst_addr",    64'(bus.write_addr_o), 64'd0);
    check("t6_rst_data",    64'(bus.write_data_o), 64'd0);
    check("t6_rst_pending", 64'(bus.pending_o),    64'd0);
    check("t6_rst_stall",   64'(bus.stall_o),      64'd0);
    check("t6_rst_ready",   64'(bus.b_ready_o),    64'd1);
    rst_n = 1'b1;
    step();
    check("t6_no_drain", 64'(bus.write_en_o), 64'd0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
